// File: rtl/change_pkg.sv
`default_nettype none
// ============================================================================
// Module   : change_pkg
// Purpose  : Shared state encoding and coin values for the change dispenser.
// Revision : 1.0  initial release
// ============================================================================
package change_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEL   = 3'd1,
      PULSE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4,
      FAULT = 3'd5
   } state_t;

   localparam int COIN5_VAL = 5;
   localparam int COIN1_VAL = 1;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : edge_sync
// Purpose  : Two-flop synchroniser followed by a one-cycle rising-edge pulse.
// Revision : 1.0  initial release
// ============================================================================
module edge_sync (
   input  logic Clock,
   input  logic Reset,
   input  logic Async_sig,
   output logic Rise_pulse
);
   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= Async_sig;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign Rise_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays back change coin by coin with sensor confirmation, timeout
//            and retry. Define CHANGE_5_EN to enable the 5-yuan hopper.
// Revision : 1.0  initial release
// ============================================================================
module change_dispenser
   import change_pkg::*;
#(
   parameter int CREDIT_W    = 4,
   parameter int PULSE_CYC   = 1000,
   parameter int TIMEOUT_CYC = 50000,
   parameter int RETRIES     = 2
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic [CREDIT_W-1:0] Credit,
   input  logic                Coin_out,
   output logic                Eject_5,
   output logic                Eject_1,
   output logic                Busy,
   output logic                Done,
   output logic                Fault,
   output logic [CREDIT_W-1:0] Remaining
);
   localparam int c_pls_w = $clog2(PULSE_CYC) + 1;
   localparam int c_tmo_w = $clog2(TIMEOUT_CYC) + 1;
   localparam int c_rty_w = $clog2(RETRIES) + 1;
   localparam logic [CREDIT_W-1:0] c_coin1 = CREDIT_W'(COIN1_VAL);
`ifdef CHANGE_5_EN
   localparam logic [CREDIT_W-1:0] c_coin5 = CREDIT_W'(COIN5_VAL);
`endif

   state_t              r_state;
   state_t              w_state_next;
   logic [CREDIT_W-1:0] r_remaining;
   logic [c_tmo_w-1:0]  r_tmo_cnt;
   logic [c_pls_w-1:0]  r_pls_cnt;
   logic [c_rty_w-1:0]  r_retry;
   logic                r_eject1;
   logic                r_busy;
   logic                r_done;
   logic                r_fault;
   logic                w_coin_edge;
   logic                w_start_ok;
   logic                w_in_flight;
   logic                w_timeout;
   logic                w_retry_left;
   logic [CREDIT_W-1:0] w_coin_val;
   logic [CREDIT_W-1:0] w_rem_after;
   logic                w_eject1_d;
   logic                w_busy_d;
   logic                w_done_d;
   logic                w_fault_d;
`ifdef CHANGE_5_EN
   logic                r_coin5;
   logic                r_eject5;
   logic                w_coin5_sel;
   logic                w_eject5_d;
`endif

   edge_sync u_coin_sync (
      .Clock      (Clock),
      .Reset      (Reset),
      .Async_sig  (Coin_out),
      .Rise_pulse (w_coin_edge)
   );

   assign w_start_ok   = Start && ((r_state == IDLE) || (r_state == DONE) || (r_state == FAULT));
   assign w_in_flight  = (r_state == PULSE) || (r_state == WAIT);
   assign w_timeout    = (r_tmo_cnt == '0);
   assign w_retry_left = (r_retry < c_rty_w'(RETRIES));
`ifdef CHANGE_5_EN
   // Selection is made in SEL and then held for the whole attempt.
   assign w_coin5_sel  = (r_state == SEL) ? (r_remaining >= c_coin5) : r_coin5;
   assign w_coin_val   = r_coin5 ? c_coin5 : c_coin1;
`else
   assign w_coin_val   = c_coin1;
`endif
   assign w_rem_after  = r_remaining - w_coin_val;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE, FAULT: begin
            if (w_start_ok) begin
               w_state_next = (Credit == '0) ? DONE : SEL;
            end else if (r_state == DONE) begin
               w_state_next = IDLE;
            end
         end
         SEL: w_state_next = PULSE;
         PULSE, WAIT: begin
            // A confirmed coin wins over a timeout in the same cycle.
            if (w_coin_edge) begin
               w_state_next = (w_rem_after == '0) ? DONE : SEL;
            end else if (w_timeout) begin
               w_state_next = w_retry_left ? SEL : FAULT;
            end else if ((r_state == PULSE) && (r_pls_cnt == '0)) begin
               w_state_next = WAIT;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_busy_d   = (w_state_next == SEL) || (w_state_next == PULSE) || (w_state_next == WAIT);
      w_done_d   = (w_state_next == DONE);
      w_fault_d  = (w_state_next == FAULT);
`ifdef CHANGE_5_EN
      w_eject5_d = (w_state_next == PULSE) && w_coin5_sel;
      w_eject1_d = (w_state_next == PULSE) && !w_coin5_sel;
`else
      w_eject1_d = (w_state_next == PULSE);
`endif
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_remaining <= '0;
         r_tmo_cnt   <= '0;
         r_pls_cnt   <= '0;
         r_retry     <= '0;
         r_eject1    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
`ifdef CHANGE_5_EN
         r_coin5     <= 1'b0;
         r_eject5    <= 1'b0;
`endif
      end else begin
         r_eject1 <= w_eject1_d;
         r_busy   <= w_busy_d;
         r_done   <= w_done_d;
         r_fault  <= w_fault_d;
`ifdef CHANGE_5_EN
         r_eject5 <= w_eject5_d;
`endif
         if (w_start_ok) begin
            r_remaining <= Credit;
            r_retry     <= '0;
         end
         if (r_state == SEL) begin
            r_tmo_cnt <= c_tmo_w'(TIMEOUT_CYC);
            r_pls_cnt <= c_pls_w'(PULSE_CYC - 1);
`ifdef CHANGE_5_EN
            r_coin5   <= w_coin5_sel;
`endif
         end
         if (w_in_flight) begin
            if (r_tmo_cnt != '0) begin
               r_tmo_cnt <= r_tmo_cnt - c_tmo_w'(1);
            end
            if (r_pls_cnt != '0) begin
               r_pls_cnt <= r_pls_cnt - c_pls_w'(1);
            end
            if (w_coin_edge) begin
               r_remaining <= w_rem_after;
               r_retry     <= '0;
            end else if (w_timeout && w_retry_left) begin
               r_retry <= r_retry + c_rty_w'(1);
            end
         end
      end
   end

`ifdef CHANGE_5_EN
   assign Eject_5 = r_eject5;
`else
   assign Eject_5 = 1'b0;
`endif
   assign Eject_1   = r_eject1;
   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Fault     = r_fault;
   assign Remaining = r_remaining;

endmodule
`default_nettype wire
